// File: rtl/twos_comp_unit.sv
// Multi-cycle two's-complement / sign unit: pass, negate, abs, one's complement.
// The operand is processed CHUNK bits per cycle, LSB first, with a registered carry.
module twos_comp_unit #(
    parameter int WIDTH = 8,
    parameter int CHUNK = 2
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    input  logic [1:0]       in_op,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    output logic             out_ovf,
    output logic             out_zero
);

    localparam int NCHUNK = WIDTH / CHUNK;
    localparam int CW     = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;
    localparam logic [WIDTH-1:0] MIN_VAL = {1'b1, {(WIDTH-1){1'b0}}};

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_t;

    typedef enum logic [1:0] {
        OP_PASS = 2'b00,
        OP_NEG  = 2'b01,
        OP_ABS  = 2'b10,
        OP_INV  = 2'b11
    } op_t;

    state_t            state_q, state_d;
    logic [WIDTH-1:0]  work_q, work_d;
    logic [CW-1:0]     cnt_q, cnt_d;
    logic              carry_q, carry_d;
    logic              inv_q, inv_d;
    logic              ovf_q, ovf_d;
    logic [WIDTH-1:0]  out_data_q, out_data_d;
    logic              out_ovf_q, out_ovf_d;
    logic              out_zero_q, out_zero_d;

    logic              sign;
    logic              is_neg, is_abs, is_inv;
    logic [CHUNK-1:0]  chunk;
    logic [CHUNK:0]    sum;

    assign in_ready  = (state_q == IDLE);
    assign out_valid = (state_q == DONE);
    assign out_data  = out_data_q;
    assign out_ovf   = out_ovf_q;
    assign out_zero  = out_zero_q;

    assign sign   = in_data[WIDTH-1];
    assign is_neg = (in_op == OP_NEG);
    assign is_abs = (in_op == OP_ABS);
    assign is_inv = (in_op == OP_INV);

    // Result chunks shift in from the top while operand chunks leave at the bottom.
    assign chunk = work_q[CHUNK-1:0];
    assign sum   = {1'b0, (inv_q ? ~chunk : chunk)} + {{CHUNK{1'b0}}, carry_q};

    always_comb begin
        state_d    = state_q;
        work_d     = work_q;
        cnt_d      = cnt_q;
        carry_d    = carry_q;
        inv_d      = inv_q;
        ovf_d      = ovf_q;
        out_data_d = out_data_q;
        out_ovf_d  = out_ovf_q;
        out_zero_d = out_zero_q;

        unique case (state_q)
            IDLE: begin
                if (in_valid) begin
                    state_d = BUSY;
                    work_d  = in_data;
                    cnt_d   = '0;
                    inv_d   = is_neg | is_inv | (is_abs & sign);
                    carry_d = is_neg | (is_abs & sign);
                    ovf_d   = (is_neg | is_abs) && (in_data == MIN_VAL);
                end
            end
            BUSY: begin
                work_d  = (work_q >> CHUNK)
                        | (WIDTH'(sum[CHUNK-1:0]) << (WIDTH - CHUNK));
                carry_d = sum[CHUNK];
                cnt_d   = cnt_q + CW'(1);
                if (cnt_q == CW'(NCHUNK - 1)) begin
                    state_d    = DONE;
                    cnt_d      = '0;
                    out_data_d = work_d;
                    out_ovf_d  = ovf_q;
                    out_zero_d = (work_d == '0);
                end
            end
            DONE: begin
                if (out_ready) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= IDLE;
            work_q     <= '0;
            cnt_q      <= '0;
            carry_q    <= 1'b0;
            inv_q      <= 1'b0;
            ovf_q      <= 1'b0;
            out_data_q <= '0;
            out_ovf_q  <= 1'b0;
            out_zero_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            work_q     <= work_d;
            cnt_q      <= cnt_d;
            carry_q    <= carry_d;
            inv_q      <= inv_d;
            ovf_q      <= ovf_d;
            out_data_q <= out_data_d;
            out_ovf_q  <= out_ovf_d;
            out_zero_q <= out_zero_d;
        end
    end

endmodule

// File: tb/tb_twos_comp_unit.sv
// Scoreboard bench for twos_comp_unit across three WIDTH/CHUNK configurations.
module tb_twos_comp_unit;

    typedef struct packed {
        logic [15:0] d;
        logic        ovf;
        logic        zero;
    } exp_t;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [15:0] in_data = '0;
    logic [1:0]  in_op = '0;
    logic [2:0]  iv = '0;
    logic [2:0]  ordy = '0;
    logic [2:0]  ir, ov, oovf, ozero;
    logic [7:0]  od0, od1;
    logic [15:0] od2;

    exp_t sb[$];
    int   n_chk = 0;
    int   n_fail = 0;

    always #5 clk = ~clk;

    twos_comp_unit #(.WIDTH(8), .CHUNK(2)) dut0 (
        .clk(clk), .reset(reset),
        .in_valid(iv[0]), .in_ready(ir[0]),
        .in_data(in_data[7:0]), .in_op(in_op),
        .out_valid(ov[0]), .out_ready(ordy[0]),
        .out_data(od0), .out_ovf(oovf[0]), .out_zero(ozero[0])
    );

    twos_comp_unit #(.WIDTH(8), .CHUNK(8)) dut1 (
        .clk(clk), .reset(reset),
        .in_valid(iv[1]), .in_ready(ir[1]),
        .in_data(in_data[7:0]), .in_op(in_op),
        .out_valid(ov[1]), .out_ready(ordy[1]),
        .out_data(od1), .out_ovf(oovf[1]), .out_zero(ozero[1])
    );

    twos_comp_unit #(.WIDTH(16), .CHUNK(4)) dut2 (
        .clk(clk), .reset(reset),
        .in_valid(iv[2]), .in_ready(ir[2]),
        .in_data(in_data), .in_op(in_op),
        .out_valid(ov[2]), .out_ready(ordy[2]),
        .out_data(od2), .out_ovf(oovf[2]), .out_zero(ozero[2])
    );

    function automatic int wdt(int c);
        return (c == 2) ? 16 : 8;
    endfunction

    function automatic int nch(int c);
        return (c == 1) ? 1 : 4;
    endfunction

    function automatic logic [15:0] get_od(int c);
        case (c)
            0:       return {8'h00, od0};
            1:       return {8'h00, od1};
            default: return od2;
        endcase
    endfunction

    function automatic exp_t model(int c, logic [15:0] d, logic [1:0] op);
        exp_t        e;
        int          w;
        logic [15:0] mask, mn, neg, r;
        logic        s;
        w    = wdt(c);
        mask = (w == 16) ? 16'hFFFF : ((16'd1 << w) - 16'd1);
        mn   = 16'd1 << (w - 1);
        d    = d & mask;
        s    = (d & mn) != 16'd0;
        neg  = (16'd0 - d) & mask;
        case (op)
            2'b00:   r = d;
            2'b01:   r = neg;
            2'b10:   r = s ? neg : d;
            default: r = ~d & mask;
        endcase
        e.d    = r;
        e.ovf  = (op == 2'b01 || op == 2'b10) && (d == mn);
        e.zero = (r == 16'd0);
        return e;
    endfunction

    task automatic chk(string tag, logic [31:0] got, logic [31:0] exp);
        n_chk++;
        assert (got === exp) else begin
            n_fail++;
            $error("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Called at a negedge; returns at the first negedge after acceptance.
    task automatic send(int c, logic [15:0] d, logic [1:0] op);
        int n;
        in_data = d;
        in_op   = op;
        iv[c]   = 1'b1;
        n = 0;
        while (!ir[c] && n < 100) begin
            @(negedge clk);
            n++;
        end
        chk("accept", 32'(ir[c]), 32'd1);
        sb.push_back(model(c, d, op));
        @(negedge clk);
        iv[c]   = 1'b0;
        in_data = 16'($urandom);
        in_op   = 2'($urandom);
    endtask

    task automatic wait_valid(int c, output int lat);
        lat = 1;
        while (!ov[c] && lat < 60) begin
            chk("in_ready_busy", 32'(ir[c]), 32'd0);
            @(negedge clk);
            lat++;
        end
        chk("out_valid_seen", 32'(ov[c]), 32'd1);
    endtask

    task automatic check_out(int c, exp_t e);
        chk("out_data", 32'(get_od(c)), 32'(e.d));
        chk("out_ovf", 32'(oovf[c]), 32'(e.ovf));
        chk("out_zero", 32'(ozero[c]), 32'(e.zero));
    endtask

    task automatic collect(int c, int stall, bit chk_lat);
        int   lat;
        exp_t e;
        wait_valid(c, lat);
        if (chk_lat) chk("latency", 32'(lat - 1), 32'(nch(c)));
        if (sb.size() == 0) begin
            chk("sb_nonempty", 32'd0, 32'd1);
            return;
        end
        e = sb.pop_front();
        for (int i = 0; i < stall; i++) begin
            check_out(c, e);
            chk("stall_valid", 32'(ov[c]), 32'd1);
            chk("stall_in_ready", 32'(ir[c]), 32'd0);
            @(negedge clk);
        end
        check_out(c, e);
        ordy[c] = 1'b1;
        @(negedge clk);
        ordy[c] = 1'b0;
        chk("valid_fall", 32'(ov[c]), 32'd0);
        chk("ready_rise", 32'(ir[c]), 32'd1);
    endtask

    initial begin
        int          lat;
        exp_t        e;
        logic [15:0] d;
        logic [1:0]  op;

        repeat (3) @(negedge clk);
        chk("rst_in_ready", 32'(ir[0]), 32'd1);
        chk("rst_out_valid", 32'(ov[0]), 32'd0);
        chk("rst_out_data", 32'(od0), 32'd0);
        chk("rst_ovf", 32'(oovf[0]), 32'd0);
        chk("rst_zero", 32'(ozero[0]), 32'd0);
        reset = 1'b0;
        @(negedge clk);

        send(0, 16'h002F, 2'b01); collect(0, 0, 1);
        send(0, 16'h0080, 2'b01); collect(0, 0, 1);
        send(0, 16'h0080, 2'b10); collect(0, 0, 1);
        send(0, 16'h0080, 2'b00); collect(0, 0, 1);
        send(0, 16'h0080, 2'b11); collect(0, 0, 1);
        send(0, 16'h00D1, 2'b10); collect(0, 0, 1);
        send(0, 16'h002F, 2'b10); collect(0, 0, 1);
        send(0, 16'h0000, 2'b01); collect(0, 0, 1);
        send(0, 16'h0001, 2'b01); collect(0, 0, 1);

        // Backpressure with the next operand already waiting.
        send(0, 16'h002F, 2'b01);
        wait_valid(0, lat);
        e = sb.pop_front();
        in_data = 16'h0011;
        in_op   = 2'b01;
        iv[0]   = 1'b1;
        for (int i = 0; i < 5; i++) begin
            check_out(0, e);
            chk("bp_valid", 32'(ov[0]), 32'd1);
            chk("bp_in_ready", 32'(ir[0]), 32'd0);
            @(negedge clk);
        end
        check_out(0, e);
        ordy[0] = 1'b1;
        @(negedge clk);
        ordy[0] = 1'b0;
        chk("bp_valid_fall", 32'(ov[0]), 32'd0);
        chk("bp_ready_rise", 32'(ir[0]), 32'd1);
        send(0, 16'h0011, 2'b01);
        collect(0, 0, 1);

        // Reset in the middle of BUSY, after chunk 1.
        send(0, 16'h002F, 2'b01);
        void'(sb.pop_front());
        @(negedge clk);
        @(negedge clk);
        #1 reset = 1'b1;
        #1;
        chk("mid_rst_in_ready", 32'(ir[0]), 32'd1);
        chk("mid_rst_valid", 32'(ov[0]), 32'd0);
        chk("mid_rst_data", 32'(od0), 32'd0);
        chk("mid_rst_ovf", 32'(oovf[0]), 32'd0);
        chk("mid_rst_zero", 32'(ozero[0]), 32'd0);
        @(negedge clk);
        reset = 1'b0;
        for (int i = 0; i < 6; i++) begin
            chk("no_valid_after_rst", 32'(ov[0]), 32'd0);
            @(negedge clk);
        end
        send(0, 16'h0005, 2'b01); collect(0, 0, 1);

        send(1, 16'h002F, 2'b01); collect(1, 0, 1);
        send(2, 16'h8000, 2'b01); collect(2, 0, 1);
        send(2, 16'h1234, 2'b01); collect(2, 0, 1);

        for (int c = 0; c < 3; c++) begin
            for (int i = 0; i < 200; i++) begin
                d = 16'($urandom);
                case ($urandom_range(0, 7))
                    0:       d = 16'd1 << (wdt(c) - 1);
                    1:       d = 16'd0;
                    default: ;
                endcase
                if (wdt(c) == 8) d[15:8] = 8'h00;
                op = 2'($urandom_range(0, 3));
                send(c, d, op);
                collect(c, $urandom_range(0, 2), 1);
            end
        end

        $display("%0d/%0d checks passed", n_chk - n_fail, n_chk);
        $finish;
    end

endmodule
